// File: rtl/encoder_pkg.sv
// Shared types and RV32I encoding constants for the instruction encoder.
package encoder_pkg;

  typedef enum logic [1:0] {
    OP_ADDI    = 2'b00,
    OP_BNE     = 2'b01,
    OP_FINISH  = 2'b10,
    OP_ILLEGAL = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WRITE = 2'b01,
    DONE  = 2'b10
  } state_e;

  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [2:0] F3_ADDI    = 3'b000;
  localparam logic [2:0] F3_BNE     = 3'b001;

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: symbolic op and fields to an RV32I word, zero latency.
// No state, no handshake; misalign flags a BNE byte offset with bit 0 set.
module instr_pack
  import encoder_pkg::*;
(
  input  op_e         op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [12:0] imm,
  output logic [31:0] word,
  output logic        misalign
);

  always_comb begin
    word     = '0;
    misalign = 1'b0;
    case (op)
      OP_ADDI: word = {imm[11:0], rs1, F3_ADDI, rd, OPC_IMM};
      OP_BNE: begin
        // B-type scatters the offset; bit 0 is implicit and must be zero
        word     = {imm[12], imm[10:5], rs2, rs1, F3_BNE, imm[4:1], imm[11], OPC_BRANCH};
        misalign = imm[0];
      end
      default: word = '0;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Program loader: one instruction per in_valid/in_ready handshake, written to sequential addresses.
// Latency: accept edge then one WRITE cycle minimum; WRITE holds until mem_ready, in_ready low meanwhile.
module instr_encoder
  import encoder_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_op,
  input  logic [4:0]            in_rd,
  input  logic [4:0]            in_rs1,
  input  logic [4:0]            in_rs2,
  input  logic [12:0]           in_imm,
  input  logic                  clear,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ready,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  done,
  output logic                  err
);

  localparam logic [ADDR_WIDTH:0] FULL = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_e                state, state_nxt;
  logic [ADDR_WIDTH:0]   count_nxt;
  logic [DATA_WIDTH-1:0] wdata_nxt;
  logic                  done_nxt, err_nxt;
  logic [31:0]           pack_word;
  logic                  misalign;
  op_e                   op;

  assign op = op_e'(in_op);

  instr_pack u_pack (
    .op       (op),
    .rd       (in_rd),
    .rs1      (in_rs1),
    .rs2      (in_rs2),
    .imm      (in_imm),
    .word     (pack_word),
    .misalign (misalign)
  );

  // Both strobes decode straight from state so reset drops mem_we without waiting for an edge
  assign in_ready = (state == IDLE);
  assign mem_we   = (state == WRITE);
  assign mem_addr = count[ADDR_WIDTH-1:0];

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    wdata_nxt = mem_wdata;
    done_nxt  = done;
    err_nxt   = err;
    if (clear) begin
      state_nxt = IDLE;
      count_nxt = '0;
      done_nxt  = 1'b0;
      err_nxt   = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            case (op)
              OP_ADDI: begin
                wdata_nxt = pack_word;
                state_nxt = WRITE;
              end
              OP_BNE: begin
                if (misalign) begin
                  err_nxt = 1'b1;
                end else begin
                  wdata_nxt = pack_word;
                  state_nxt = WRITE;
                end
              end
              OP_FINISH: begin
                done_nxt  = 1'b1;
                state_nxt = DONE;
              end
              default: err_nxt = 1'b1;
            endcase
          end
        end
        WRITE: begin
          if (mem_ready) begin
            count_nxt = count + 1'b1;
            if (count + 1'b1 == FULL) begin
              done_nxt  = 1'b1;
              state_nxt = DONE;
            end else begin
              state_nxt = IDLE;
            end
          end
        end
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= '0;
      mem_wdata <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      count     <= count_nxt;
      mem_wdata <= wdata_nxt;
      done      <= done_nxt;
      err       <= err_nxt;
    end
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Instruction encoder and program loader: the producer side of the 32-bit instruction word consumed by the control unit. It accepts one symbolic instruction per handshake (ADDI or BNE fields), packs it into a RISC-V RV32I word, and writes it to sequential instruction-memory addresses starting at 0. Test benches and the boot path use it to fill instruction memory without hand-assembled hex.

## Interface

Parameters:
- DATA_WIDTH, 32, instruction word width; must be 32.
- ADDR_WIDTH, 8, instruction-memory word-address width; capacity DEPTH = 2**ADDR_WIDTH words.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input instruction present.
- in_ready  out  1  encoder can accept; equals (state == IDLE).
- in_op  in  2  00 ADDI, 01 BNE, 10 FINISH, 11 illegal.
- in_rd  in  5  destination register (ADDI).
- in_rs1  in  5  source register 1.
- in_rs2  in  5  source register 2 (BNE).
- in_imm  in  13  signed immediate; ADDI uses [11:0]; BNE uses the byte offset [12:0].
- clear  in  1  synchronous; return to IDLE, count and address to 0, err to 0.
- mem_we  out  1  memory write strobe.
- mem_addr  out  ADDR_WIDTH  word address of current write.
- mem_wdata  out  DATA_WIDTH  encoded instruction.
- mem_ready  in  1  memory accepts the write this cycle.
- count  out  ADDR_WIDTH+1  words written so far.
- done  out  1  program finished or memory full.
- err  out  1  sticky; an instruction was rejected.

## Operation

- States: IDLE, WRITE, DONE.
- Reset (async, rst_n low): state IDLE; mem_we 0, mem_addr 0, mem_wdata 0, count 0, done 0, err 0. in_ready is 1 once in IDLE.
- IDLE, accept (in_valid & in_ready):
  - ADDI: wdata = {imm[11:0], rs1, 3'b000, rd, 7'b0010011}. Go to WRITE.
  - BNE: wdata = {imm[12], imm[10:5], rs2, rs1, 3'b001, imm[4:1], imm[11], 7'b1100011}. Go to WRITE. If imm[0] = 1, the offset is misaligned: set err, write nothing, stay IDLE.
  - FINISH: set done. Go to DONE. Nothing is written.
  - Illegal op (11): set err, drop the instruction, stay IDLE.
- WRITE: mem_we = 1. mem_addr and mem_wdata are held stable. When mem_ready = 1 at a rising edge:
  - Drop mem_we and increment count.
  - Move to the next address. If count becomes DEPTH, set done and go to DONE. Otherwise go to IDLE.
- DONE: in_ready 0. Input is ignored until clear.
- clear has priority over every transition in every state. An in-flight write is abandoned: mem_we drops on the next edge.
- mem_addr = count[ADDR_WIDTH-1:0]. No wrap-around: a full memory forces DONE.
- Register fields are forwarded unmodified; x0 destinations are legal.

## Timing

- Accept at edge N. mem_we is high in cycles N+1 … M, where M is the first edge with mem_ready = 1. in_ready returns at M+1.
- Peak throughput: one instruction every 2 cycles.
- While mem_we = 1, mem_addr and mem_wdata must not change.
- mem_ready outside WRITE is ignored.
- err and done are registered and sticky. They assert the cycle after the triggering edge.
- rst_n asserted mid-WRITE aborts immediately: mem_we goes to 0 asynchronously and the memory contents are undefined for that word.

## Structure

- Package encoder_pkg holds:
  - op enum: OP_ADDI, OP_BNE, OP_FINISH, OP_ILLEGAL.
  - Opcode constants: OPC_IMM = 7'b0010011, OPC_BRANCH = 7'b1100011.
  - funct3 constants: F3_ADDI = 3'b000, F3_BNE = 3'b001.
  - The state enum.
- Sub-module instr_pack (combinational): op, fields → 32-bit word plus misalign flag. It can be reused by a future disassembler cross-check.
- The top module holds the FSM, the address/count register and the output registers.

## Test plan

- ADDI rd=1, rs1=0, imm=5 with mem_ready tied 1 → one mem_we pulse, addr 0, wdata 0x00500093, count 1.
- ADDI rd=2, rs1=0, imm=13'h1FFF (−1), then BNE rs1=1, rs2=2, imm=−8 → addr 0 wdata 0xFFF00113, addr 1 wdata 0xFE209CE3.
- mem_ready low for 3 cycles during WRITE → mem_we, addr and wdata stable for 4 cycles; in_ready 0 throughout; count increments once.
- BNE with imm=3, then op=11 → err=1, no mem_we, count 0; a following ADDI is still written at addr 0.
- ADDR_WIDTH=2: four ADDIs → done=1 after the 4th write, count 4, in_ready 0; a fifth in_valid is ignored. Then clear → count 0, done 0, in_ready 1.
- FINISH after two writes → done=1, count 2. Also: rst_n pulsed low mid-WRITE → mem_we 0 immediately, all outputs at reset values.
